// File: rtl/input_port_unit.sv
// input_port_unit: router input port with a flit FIFO,
// XY route compute and switch-allocator request/grant.
module input_port_unit #(
  parameter int DEPTH = 4,
  parameter int X_ID  = 0,
  parameter int Y_ID  = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] flit_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        req_o,
  input  logic        grant_i,
  input  logic        out_ready_i,
  output logic [2:0]  sel_demux_o,
  output logic        enable_o,
  output logic [15:0] data_o,
  output logic        err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [3:0] XI = 4'(X_ID);
  localparam logic [3:0] YI = 4'(Y_ID);

  localparam logic [2:0] P_N = 3'd0;
  localparam logic [2:0] P_S = 3'd1;
  localparam logic [2:0] P_W = 3'd2;
  localparam logic [2:0] P_E = 3'd3;
  localparam logic [2:0] P_L = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    REQ,
    SEND
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    sel_q, sel_d;
  logic          err_q, err_d;
  logic          sent_q, sent_d;

  logic [15:0]   mem_q [DEPTH];

  logic          push;
  logic          pop;
  logic          fire;
  logic          empty;
  logic [15:0]   head;

  // Dimension-ordered route: resolve X first, then Y,
  // local port when both coordinates match.
  function automatic logic [2:0] xy_route(
    input logic [15:0] f
  );
    logic [3:0] dx;
    logic [3:0] dy;
    dx = f[7:4];
    dy = f[3:0];
    xy_route = P_L;
    unique case (1'b1)
      (dx > XI):               xy_route = P_E;
      (dx < XI):               xy_route = P_W;
      (dx == XI && dy > YI):   xy_route = P_N;
      (dx == XI && dy < YI):   xy_route = P_S;
      (dx == XI && dy == YI):  xy_route = P_L;
    endcase
  endfunction

  assign head        = mem_q[rd_ptr_q];
  assign empty       = (count_q == '0);
  assign ready_o     = (count_q < FULL);
  assign push        = valid_i & ready_o;
  assign data_o      = head;
  assign sel_demux_o = sel_q;
  assign err_o       = err_q;
  assign enable_o    = fire;

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Packet FSM: drop stray body flits, route head,
  // request the switch, then stream until the tail.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = err_q;
    sent_d  = sent_q;
    pop     = 1'b0;
    fire    = 1'b0;
    req_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head[15]) begin
            state_d = ROUTE;
          end else begin
            pop   = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      ROUTE: begin
        sel_d   = xy_route(head);
        state_d = REQ;
      end
      REQ: begin
        req_o = 1'b1;
        if (grant_i) begin
          state_d = SEND;
          sent_d  = 1'b0;
        end
      end
      SEND: begin
        req_o = 1'b1;
        fire  = !empty && out_ready_i;
        if (fire) begin
          pop    = 1'b1;
          sent_d = 1'b1;
          if (sent_q && head[15]) err_d = 1'b1;
          if (head[14]) state_d = IDLE;
        end
      end
    endcase
  end

  // Control state; buffered flits are abandoned on reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sel_q    <= 3'd0;
      err_q    <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      sent_q   <= sent_d;
    end
  end

  // Flit storage, written on push only; never cleared.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= flit_i;
  end

endmodule
